// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the execute-stage ALU.
package alu_pkg;

    // Alu_Control encodings produced by the ALU decoder
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b101;

    // Control FSM states of the execute unit
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE    = 2'd2
    } alu_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle for WIDTH cycles.
// Produces the low WIDTH bits of the product, which are the same for signed and unsigned operands.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // product is the accumulator including the current step, so the final
    // value is available in the same cycle the last iteration runs
    assign product = w_acc_next;
    assign busy    = (r_count != '0);
    assign last    = (r_count == CNT_W'(1));

    // Load operands on request, then shift-add once per cycle until the count expires
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (load) begin
            r_acc    <= '0;
            r_mcand  <= SrcA;
            r_mplier <= SrcB;
            r_count  <= CNT_W'(WIDTH);
        end else if (r_count != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a WIDTH-cycle iterative multiply.
// Busy/Stall let the hazard unit freeze the pipeline while a multiply is in flight.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Alu_Control,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Alu_Result,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);
    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_accept;
    logic             w_take;
    logic             w_is_mul;
    logic             w_load_mul;
    logic             w_mul_busy;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_product;

    assign w_accept   = (r_state == IDLE) || (r_state == DONE);
    assign w_take     = w_accept & Start;
    assign w_is_mul   = (Alu_Control == ALU_MUL);
    assign w_load_mul = w_take & w_is_mul;

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .load    (w_load_mul),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .busy    (w_mul_busy),
        .last    (w_mul_last),
        .product (w_mul_product)
    );

    // Single-cycle datapath; reserved codes evaluate to zero
    always_comb begin
        w_alu_result = '0;
        case (Alu_Control)
            ALU_AND: w_alu_result = SrcA & SrcB;
            ALU_OR:  w_alu_result = SrcA | SrcB;
            ALU_ADD: w_alu_result = SrcA + SrcB;
            ALU_SUB: w_alu_result = SrcA - SrcB;
            ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: w_alu_result = '0;
        endcase
    end

    // Next-state logic: DONE accepts a new op exactly like IDLE does
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (Start) w_state_next = w_is_mul ? MUL_RUN : DONE;
            end
            MUL_RUN: begin
                if (w_mul_last) w_state_next = DONE;
            end
            DONE: begin
                if (Start) w_state_next = w_is_mul ? MUL_RUN : DONE;
                else       w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Result/Zero registers update only when an op completes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_take && !w_is_mul) begin
            r_result <= w_alu_result;
            r_zero   <= (w_alu_result == '0);
        end else if ((r_state == MUL_RUN) && w_mul_last) begin
            r_result <= w_mul_product;
            r_zero   <= (w_mul_product == '0);
        end
    end

    assign Alu_Result = r_result;
    assign Zero       = r_zero;
    assign Busy       = (r_state == MUL_RUN) & w_mul_busy;
    assign Done       = (r_state == DONE);
    assign Stall      = Busy | w_load_mul;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;
    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_SUB = 3'b100;
    localparam logic [2:0] C_SLT = 3'b110;
    localparam logic [2:0] C_MUL = 3'b101;

    logic             CLK;
    logic             RST;
    logic             Start;
    logic [2:0]       Alu_Control;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] Alu_Result;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic             Stall;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Start       (Start),
        .Alu_Control (Alu_Control),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Alu_Result  (Alu_Result),
        .Zero        (Zero),
        .Busy        (Busy),
        .Done        (Done),
        .Stall       (Stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: what each op code means arithmetically
    function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] code,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        longint unsigned prod;
        case (code)
            C_AND: return a & b;
            C_OR:  return a | b;
            C_ADD: return a + b;
            C_SUB: return a - b;
            C_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            C_MUL: begin
                prod = longint'(a) * longint'(b);
                return prod[WIDTH-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Issue one op from an idle unit and check latency, result, Zero and Done pulse
    task automatic run_op(input logic [2:0] code, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] got);
        logic [WIDTH-1:0] exp;
        int n;
        int exp_lat;
        exp     = ref_alu(code, a, b);
        exp_lat = (code == C_MUL) ? WIDTH : 0;
        @(negedge CLK);
        Start = 1'b1; Alu_Control = code; SrcA = a; SrcB = b;
        #1;
        n_cmp++;
        if (Stall !== (code == C_MUL)) begin
            n_fail++;
            $display("FAIL run_op_stall code=%b got=%b exp=%b", code, Stall, (code == C_MUL));
        end
        @(negedge CLK);
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        got = Alu_Result;
        $display("op=%b a=%h b=%h result=%h exp=%h zero=%b lat=%0d", code, a, b, Alu_Result, exp, Zero, n);
        n_cmp++;
        if (n !== exp_lat) begin
            n_fail++;
            $display("FAIL run_op_latency code=%b got=%0d exp=%0d", code, n, exp_lat);
        end
        n_cmp++;
        if (Alu_Result !== exp) begin
            n_fail++;
            $display("FAIL run_op_result code=%b a=%h b=%h got=%h exp=%h", code, a, b, Alu_Result, exp);
        end
        n_cmp++;
        if (Zero !== (exp == '0)) begin
            n_fail++;
            $display("FAIL run_op_zero code=%b got=%b exp=%b", code, Zero, (exp == '0));
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_op_busy_at_done code=%b got=%b exp=0", code, Busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL run_op_done_pulse code=%b got=%b exp=0", code, Done);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Alu_Control = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({Alu_Result, Zero, Busy, Done, Stall} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got res=%h z=%b busy=%b done=%b stall=%b exp res=0 z=1 busy=0 done=0 stall=0",
                     Alu_Result, Zero, Busy, Done, Stall);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] got;
        run_op(C_ADD, 32'd7, 32'd5, got);
        n_cmp++;
        if (got !== 32'd12) begin
            n_fail++;
            $display("FAIL add_7_5 got=%h exp=%h", got, 32'd12);
        end
    endtask

    task automatic test_sub_slt();
        logic [WIDTH-1:0] got;
        run_op(C_SUB, 32'h1234, 32'h1234, got);
        n_cmp++;
        if (got !== 32'd0 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_equal got=%h z=%b exp=0 z=1", got, Zero);
        end
        run_op(C_SLT, 32'hFFFF_FFFF, 32'd1, got);
        n_cmp++;
        if (got !== 32'd1) begin
            n_fail++;
            $display("FAIL slt_neg got=%h exp=1", got);
        end
    endtask

    // Directed multiply with per-cycle Busy/Done checks and an ignored mid-run Start
    task automatic test_mul();
        int bad_busy = 0;
        int bad_stall = 0;
        @(negedge CLK);
        Start = 1'b1; Alu_Control = C_MUL; SrcA = 32'h0001_0003; SrcB = 32'h0000_0005;
        #1;
        n_cmp++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_stall_start got=%b exp=1", Stall);
        end
        @(negedge CLK);
        Start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) bad_busy++;
            if (Stall !== 1'b1) bad_stall++;
            if (i == 10) begin
                Start = 1'b1; Alu_Control = C_ADD; SrcA = 32'd1; SrcB = 32'd1;
            end
            if (i == 12) Start = 1'b0;
            @(negedge CLK);
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL mul_busy_window got=%0d bad cycles exp=0", bad_busy);
        end
        n_cmp++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL mul_stall_window got=%0d bad cycles exp=0", bad_stall);
        end
        $display("op=%b a=00010003 b=00000005 result=%h exp=0005000f done=%b", C_MUL, Alu_Result, Done);
        n_cmp++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Alu_Result !== 32'h0005_000F) begin
            n_fail++;
            $display("FAIL mul_done_edge33 got done=%b busy=%b res=%h exp done=1 busy=0 res=0005000f",
                     Done, Busy, Alu_Result);
        end
        @(negedge CLK);
        n_cmp++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_done_pulse got=%b exp=0", Done);
        end
    endtask

    task automatic test_mul_wrap();
        logic [WIDTH-1:0] got;
        run_op(C_MUL, 32'hFFFF_FFFF, 32'd2, got);
        n_cmp++;
        if (got !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mul_wrap_neg got=%h exp=fffffffe", got);
        end
        run_op(C_MUL, 32'h8000_0000, 32'd2, got);
        n_cmp++;
        if (got !== 32'd0 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_wrap_zero got=%h z=%b exp=0 z=1", got, Zero);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [WIDTH-1:0] got;
        int done_seen = 0;
        @(negedge CLK);
        Start = 1'b1; Alu_Control = C_MUL; SrcA = $urandom | 32'd1; SrcB = $urandom | 32'd1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Alu_Result !== 32'd0 || Zero !== 1'b1 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul got busy=%b res=%h z=%b done=%b exp busy=0 res=0 z=1 done=0",
                     Busy, Alu_Result, Zero, Done);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done === 1'b1 || Busy === 1'b1) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done got=%0d active cycles exp=0", done_seen);
        end
        run_op(C_ADD, 32'd1, 32'd1, got);
        n_cmp++;
        if (got !== 32'd2) begin
            n_fail++;
            $display("FAIL add_after_reset got=%h exp=2", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got;
        @(negedge CLK);
        Start = 1'b1; Alu_Control = C_ADD; SrcA = 32'd7; SrcB = 32'd5;
        @(negedge CLK);
        n_cmp++;
        if (Done !== 1'b1 || Alu_Result !== 32'd12) begin
            n_fail++;
            $display("FAIL b2b_first got done=%b res=%h exp done=1 res=0000000c", Done, Alu_Result);
        end
        Alu_Control = C_AND; SrcA = 32'hF0; SrcB = 32'h3C;
        @(negedge CLK);
        $display("op=%b a=000000f0 b=0000003c result=%h exp=00000030 done=%b", C_AND, Alu_Result, Done);
        n_cmp++;
        if (Done !== 1'b1 || Alu_Result !== 32'h30) begin
            n_fail++;
            $display("FAIL b2b_second got done=%b res=%h exp done=1 res=00000030", Done, Alu_Result);
        end
        Start = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_drop got=%b exp=0", Done);
        end
        run_op(3'b111, $urandom, $urandom, got);
        n_cmp++;
        if (got !== 32'd0 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_111 got=%h z=%b exp=0 z=1", got, Zero);
        end
    endtask

    task automatic test_random();
        logic [2:0]       codes [8];
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] got;
        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_MUL, 3'b011, 3'b111};
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 4) == 0) a = '0;
            run_op(codes[$urandom_range(0, 7)], a, b, got);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_mul();
        test_mul_wrap();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
